devil_snoop_responder: RTL and testbench

Snoop responder that answers ACE snoop requests on the AC/CR/CD channels on behalf of the devil controller. It accepts one snoop at a time on AC and signals the controller with a trigger pulse. It then waits for the controller's reply flag and cache line, returns a CR response, and streams the 512-bit line as four critical-word-first CD beats. It finishes with an end-of-reply pulse back to the controller.

---
 rtl/devil_snoop_responder.sv | 186 ++++++++++++++++++
 tb/tb_devil_snoop_responder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/devil_snoop_responder.sv
// ACE snoop responder: one snoop at a time on AC, CR reply, then a
// critical-word-first 4-beat CD burst of the line the controller returns.
// Ports: ace_aclk/ace_aresetn; AC (i_acvalid,o_acready,i_acaddr,i_acsnoop);
// CR (o_crvalid,i_crready,o_crresp); CD (o_cdvalid,i_cdready,o_cddata,
// o_cdlast); controller side (o_snoop_trigger,o_snoop_addr,o_snoop_type,
// i_reply,i_cache_line,o_end_reply,o_timeout).
// Optional macro DEVIL_REPLY_TIMEOUT_EN: bounded reply wait of
// TIMEOUT_CYCLES cycles, answered with a no-data CR on expiry.
module devil_snoop_responder #(
  parameter int C_ACE_DATA_WIDTH = 128,
  parameter int C_ACE_ADDR_WIDTH = 44,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic                          i_acvalid,
  output logic                          o_acready,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
  input  logic [3:0]                    i_acsnoop,
  output logic                          o_crvalid,
  input  logic                          i_crready,
  output logic [4:0]                    o_crresp,
  output logic                          o_cdvalid,
  input  logic                          i_cdready,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_cddata,
  output logic                          o_cdlast,
  output logic                          o_snoop_trigger,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_snoop_addr,
  output logic [3:0]                    o_snoop_type,
  input  logic                          i_reply,
  input  logic [4*C_ACE_DATA_WIDTH-1:0] i_cache_line,
  output logic                          o_end_reply,
  output logic                          o_timeout
);

  localparam int DW = C_ACE_DATA_WIDTH;
  localparam int AW = C_ACE_ADDR_WIDTH;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WAIT_REPLY,
    R_CR,
    R_CD,
    R_END
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      type_q, type_d;
  logic [1:0]      start_q, start_d;
  logic [1:0]      beat_q, beat_d;
  logic [4*DW-1:0] line_q, line_d;
  logic            has_data_q, has_data_d;
  logic            trig_q, trig_d;
  // Low during reset, high from the first clock after release, so
  // o_acready stays low while reset is held.
  logic            alive_q;
  logic [1:0]      widx;

`ifdef DEVIL_REPLY_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]     cnt_q, cnt_d;
  logic            to_q, to_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    type_d     = type_q;
    start_d    = start_q;
    beat_d     = beat_q;
    line_d     = line_q;
    has_data_d = has_data_q;
    trig_d     = 1'b0;
`ifdef DEVIL_REPLY_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = 1'b0;
`endif
    unique case (state_q)
      R_IDLE: begin
        if (i_acvalid && alive_q) begin
          addr_d     = i_acaddr;
          type_d     = i_acsnoop;
          start_d    = i_acaddr[5:4];
          has_data_d = 1'b0;
          trig_d     = 1'b1;
`ifdef DEVIL_REPLY_TIMEOUT_EN
          cnt_d      = '0;
`endif
          state_d    = R_WAIT_REPLY;
        end
      end
      R_WAIT_REPLY: begin
        // A reply on the terminal count still wins over the timeout.
        if (i_reply) begin
          line_d     = i_cache_line;
          has_data_d = 1'b1;
          state_d    = R_CR;
`ifdef DEVIL_REPLY_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          to_d       = 1'b1;
          state_d    = R_CR;
        end else begin
          cnt_d      = cnt_q + 16'd1;
`endif
        end
      end
      R_CR: begin
        beat_d = 2'd0;
        if (i_crready) begin
          state_d = has_data_q ? R_CD : R_END;
        end
      end
      R_CD: begin
        if (i_cdready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = R_END;
          end
        end
      end
      R_END: begin
        state_d = R_IDLE;
      end
      default: begin
        state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q    <= R_IDLE;
      addr_q     <= '0;
      type_q     <= '0;
      start_q    <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      has_data_q <= 1'b0;
      trig_q     <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      start_q    <= start_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      has_data_q <= has_data_d;
      trig_q     <= trig_d;
      alive_q    <= 1'b1;
    end
  end

`ifdef DEVIL_REPLY_TIMEOUT_EN
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign o_timeout = to_q;
`else
  // Constant 0: a legal TIMEOUT_CYCLES is never 0.
  assign o_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Critical word first: the 2-bit sum wraps around the line.
  assign widx = start_q + beat_q;

  assign o_acready       = alive_q && (state_q == R_IDLE);
  assign o_crvalid       = (state_q == R_CR);
  assign o_crresp        = {4'b0000, o_crvalid && has_data_q};
  assign o_cdvalid       = (state_q == R_CD);
  assign o_cddata        = o_cdvalid ? line_q[widx*DW +: DW] : '0;
  assign o_cdlast        = o_cdvalid && (beat_q == 2'd3);
  assign o_snoop_trigger = trig_q;
  assign o_snoop_addr    = addr_q;
  assign o_snoop_type    = type_q;
  assign o_end_reply     = (state_q == R_END);

endmodule

// File: tb/tb_devil_snoop_responder.sv
// Bench for devil_snoop_responder: random snoops, scoreboard queues
// filled by a line-level model, negedge monitor pops and compares.
module tb_devil_snoop_responder;

  localparam int DW = 128;
  localparam int AW = 44;
`ifdef DEVIL_REPLY_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic            clk;
  logic            rst_n;
  logic            i_acvalid;
  logic            o_acready;
  logic [AW-1:0]   i_acaddr;
  logic [3:0]      i_acsnoop;
  logic            o_crvalid;
  logic            i_crready;
  logic [4:0]      o_crresp;
  logic            o_cdvalid;
  logic            i_cdready;
  logic [DW-1:0]   o_cddata;
  logic            o_cdlast;
  logic            o_snoop_trigger;
  logic [AW-1:0]   o_snoop_addr;
  logic [3:0]      o_snoop_type;
  logic            i_reply;
  logic [4*DW-1:0] i_cache_line;
  logic            o_end_reply;
  logic            o_timeout;

  devil_snoop_responder #(
    .C_ACE_DATA_WIDTH(DW),
    .C_ACE_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ace_aclk(clk),
    .ace_aresetn(rst_n),
    .i_acvalid(i_acvalid),
    .o_acready(o_acready),
    .i_acaddr(i_acaddr),
    .i_acsnoop(i_acsnoop),
    .o_crvalid(o_crvalid),
    .i_crready(i_crready),
    .o_crresp(o_crresp),
    .o_cdvalid(o_cdvalid),
    .i_cdready(i_cdready),
    .o_cddata(o_cddata),
    .o_cdlast(o_cdlast),
    .o_snoop_trigger(o_snoop_trigger),
    .o_snoop_addr(o_snoop_addr),
    .o_snoop_type(o_snoop_type),
    .i_reply(i_reply),
    .i_cache_line(i_cache_line),
    .o_end_reply(o_end_reply),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic last; } beat_t;
  typedef struct { logic [4:0] resp; logic to; } cr_t;
  typedef struct { logic [AW-1:0] a; logic [3:0] t; } trig_t;

  beat_t exp_cd[$];
  cr_t   exp_cr[$];
  trig_t exp_trig[$];

  int checks = 0;
  int errors = 0;
  int bp = 0;
  int crs = 0;
  int cdp = 0;
  int exp_ends = 0;
  int ends_seen = 0;
  bit mon_en = 0;

  bit busy, end_due, ready_due;
  bit prev_crv, prev_crr, prev_cdv, prev_cdr, prev_last;
  logic [4:0]    prev_resp;
  logic [DW-1:0] prev_data;
  beat_t mcd;
  cr_t   mcr;
  trig_t mtr;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] rnd_line();
    logic [4*DW-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'({$urandom(), $urandom()});
  endfunction

  // Reference model: what one snoop must produce, at line level.
  task automatic model_push(input logic [AW-1:0] a, input logic [3:0] t,
                            input logic [4*DW-1:0] line, input bit noreply);
    int w;
    beat_t b;
    exp_trig.push_back('{a, t});
    if (noreply) begin
      exp_cr.push_back('{5'b00000, 1'b1});
    end else begin
      exp_cr.push_back('{5'b00001, 1'b0});
      for (int k = 0; k < 4; k++) begin
        w = (int'(a[5:4]) + k) % 4;
        b.d = line[w*DW +: DW];
        b.last = (k == 3);
        exp_cd.push_back(b);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acready"}, 512'(o_acready), 512'(0));
    chk({tag, "_crvalid"}, 512'(o_crvalid), 512'(0));
    chk({tag, "_crresp"}, 512'(o_crresp), 512'(0));
    chk({tag, "_cdvalid"}, 512'(o_cdvalid), 512'(0));
    chk({tag, "_cddata"}, 512'(o_cddata), 512'(0));
    chk({tag, "_cdlast"}, 512'(o_cdlast), 512'(0));
    chk({tag, "_trigger"}, 512'(o_snoop_trigger), 512'(0));
    chk({tag, "_addr"}, 512'(o_snoop_addr), 512'(0));
    chk({tag, "_type"}, 512'(o_snoop_type), 512'(0));
    chk({tag, "_end"}, 512'(o_end_reply), 512'(0));
    chk({tag, "_timeout"}, 512'(o_timeout), 512'(0));
  endtask

  // Ready generator: 0 = always ready, 1 = random, 2 = fixed stall pattern.
  always @(posedge clk) begin
    #1;
    if (o_crvalid) crs++; else crs = 0;
    if (o_cdvalid) cdp++; else cdp = 0;
    if (bp == 0) begin
      i_crready = 1'b1;
      i_cdready = 1'b1;
    end else if (bp == 1) begin
      i_crready = 1'($urandom_range(0, 1));
      i_cdready = 1'($urandom_range(0, 1));
    end else begin
      i_crready = (crs > 5);
      i_cdready = (cdp == 0) ? 1'b0 : pat[(cdp - 1) % 4];
    end
  end

  // Monitor: all output checking against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ready_due) begin
        chk("acready_after_end", 512'(o_acready), 512'(1));
        ready_due = 0;
        busy = 0;
      end else if (busy) begin
        chk("acready_busy", 512'(o_acready), 512'(0));
      end
      if (i_acvalid && o_acready) busy = 1;

      if (o_end_reply) ends_seen++;
      if (end_due) begin
        chk("end_reply", 512'(o_end_reply), 512'(1));
        end_due = 0;
        ready_due = 1;
      end else if (o_end_reply) begin
        chk("end_unexpected", 512'(o_end_reply), 512'(0));
      end

      if (o_snoop_trigger) begin
        if (exp_trig.size() == 0) begin
          chk("trigger_unexpected", 512'(o_snoop_trigger), 512'(0));
        end else begin
          mtr = exp_trig.pop_front();
          chk("snoop_addr", 512'(o_snoop_addr), 512'(mtr.a));
          chk("snoop_type", 512'(o_snoop_type), 512'(mtr.t));
        end
      end

      if (o_crvalid && !prev_crv) begin
        if (exp_cr.size() == 0)
          chk("cr_unexpected", 512'(o_crvalid), 512'(0));
        else
          chk("timeout_flag", 512'(o_timeout), 512'(exp_cr[0].to));
      end else if (o_timeout) begin
        chk("timeout_stray", 512'(o_timeout), 512'(0));
      end

      if (o_crvalid) begin
        if (prev_crv && !prev_crr)
          chk("cr_stable", 512'(o_crresp), 512'(prev_resp));
        if (i_crready && exp_cr.size() > 0) begin
          mcr = exp_cr.pop_front();
          chk("crresp", 512'(o_crresp), 512'(mcr.resp));
          if (!mcr.resp[0]) end_due = 1;
        end
      end

      if (o_cdvalid) begin
        if (prev_cdv && !prev_cdr) begin
          chk("cd_stable", 512'(o_cddata), 512'(prev_data));
          chk("cdlast_stable", 512'(o_cdlast), 512'(prev_last));
        end
        if (i_cdready) begin
          if (exp_cd.size() == 0) begin
            chk("cd_extra_beat", 512'(o_cdvalid), 512'(0));
          end else begin
            mcd = exp_cd.pop_front();
            chk("cddata", 512'(o_cddata), 512'(mcd.d));
            chk("cdlast", 512'(o_cdlast), 512'(mcd.last));
            if (mcd.last) end_due = 1;
          end
        end
      end

      prev_crv  = o_crvalid;
      prev_crr  = i_crready;
      prev_resp = o_crresp;
      prev_cdv  = o_cdvalid;
      prev_cdr  = i_cdready;
      prev_data = o_cddata;
      prev_last = o_cdlast;
    end
  end

  // One complete snoop. d = cycles after the trigger cycle before i_reply.
  task automatic snoop(input logic [AW-1:0] a, input logic [3:0] t,
                       input logic [4*DW-1:0] line, input int d,
                       input bit noreply, input bit ovl,
                       input logic [AW-1:0] a2, input logic [3:0] t2);
    int n;
    i_acvalid = 1'b1;
    i_acaddr  = a;
    i_acsnoop = t;
    n = 0;
    @(negedge clk);
    while (!o_acready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!o_acready) begin
      chk("ac_wait_expired", 512'(o_acready), 512'(1));
      i_acvalid = 1'b0;
      return;
    end
    model_push(a, t, line, noreply);
    exp_ends++;
    @(posedge clk);
    #1;
    i_acvalid = ovl;
    i_acaddr  = ovl ? a2 : rnd_addr();
    i_acsnoop = ovl ? t2 : 4'($urandom());
    if (!noreply && d == 0) begin
      i_reply = 1'b1;
      i_cache_line = line;
    end
    @(negedge clk);
    chk("trigger_latency", 512'(o_snoop_trigger), 512'(1));
    chk("cr_early", 512'(o_crvalid), 512'(0));
    if (noreply) begin
      repeat (TO - 1) @(negedge clk);
      chk("cr_before_timeout", 512'(o_crvalid), 512'(0));
      @(negedge clk);
      chk("cr_at_timeout", 512'(o_crvalid), 512'(1));
    end else begin
      if (d > 0) begin
        repeat (d) @(posedge clk);
        #1;
        i_reply = 1'b1;
        i_cache_line = line;
      end
      @(posedge clk);
      #1;
      i_reply = 1'b0;
      i_cache_line = rnd_line();
      @(negedge clk);
      chk("cr_latency", 512'(o_crvalid), 512'(1));
    end
    n = 0;
    while (!o_end_reply && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!o_end_reply)
      chk("end_wait_expired", 512'(o_end_reply), 512'(1));
    chk("addr_hold", 512'(o_snoop_addr), 512'(a));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4*DW-1:0] line;
    logic [AW-1:0] a;
    int n, beats;
    rst_n = 1'b0;
    i_acvalid = 1'b0;
    i_acaddr = '0;
    i_acsnoop = '0;
    i_crready = 1'b1;
    i_cdready = 1'b1;
    i_reply = 1'b0;
    i_cache_line = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held_acready", 512'(o_acready), 512'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    chk("release_acready", 512'(o_acready), 512'(1));
    @(posedge clk);
    #1;

    bp = 0;
    line = rnd_line();
    line[7:0] = 8'hc2;
    line[135:128] = 8'hac;
    line[263:256] = 8'h99;
    line[391:384] = 8'h59;
    snoop(44'h40000100, 4'b0001, line, 3, 0, 0, '0, '0);

    a = rnd_addr();
    a[5:4] = 2'b11;
    snoop(a, 4'h2, rnd_line(), 0, 0, 0, '0, '0);

    bp = 2;
    a = rnd_addr();
    a[5:4] = 2'b10;
    snoop(a, 4'h9, rnd_line(), 1, 0, 0, '0, '0);

    bp = 0;
    a = rnd_addr();
    snoop(44'h123_4567_89a0, 4'h3, rnd_line(), 2, 0, 1, a, 4'hc);
    snoop(a, 4'hc, rnd_line(), 0, 0, 0, '0, '0);

    bp = 1;
    for (int i = 0; i < 20; i++)
      snoop(rnd_addr(), 4'($urandom()), rnd_line(),
            int'($urandom_range(0, 6)), 0, 0, '0, '0);

`ifdef DEVIL_REPLY_TIMEOUT_EN
    bp = 0;
    snoop(rnd_addr(), 4'h1, rnd_line(), 0, 1, 0, '0, '0);
    snoop(rnd_addr(), 4'h1, rnd_line(), TO - 1, 0, 0, '0, '0);
    bp = 1;
    snoop(rnd_addr(), 4'h5, rnd_line(), 0, 1, 0, '0, '0);
`endif

    // Reset in the middle of the CD burst.
    bp = 0;
    line = rnd_line();
    a = rnd_addr();
    a[5:4] = 2'b01;
    i_acvalid = 1'b1;
    i_acaddr = a;
    i_acsnoop = 4'h7;
    @(negedge clk);
    chk("rst_txn_acready", 512'(o_acready), 512'(1));
    model_push(a, 4'h7, line, 0);
    @(posedge clk);
    #1;
    i_acvalid = 1'b0;
    i_reply = 1'b1;
    i_cache_line = line;
    @(posedge clk);
    #1;
    i_reply = 1'b0;
    n = 0;
    beats = 0;
    while (beats < 2 && n < 50) begin
      @(negedge clk);
      if (o_cdvalid && i_cdready) beats++;
      n++;
    end
    chk("rst_beats_before", 512'(beats), 512'(2));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mon_en = 0;
    #1;
    check_all_zero("mid_reset");
    exp_cd.delete();
    exp_cr.delete();
    exp_trig.delete();
    busy = 0;
    end_due = 0;
    ready_due = 0;
    prev_crv = 0;
    prev_cdv = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    chk("post_reset_acready", 512'(o_acready), 512'(1));
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_cdvalid", 512'(o_cdvalid), 512'(0));
      chk("post_reset_crvalid", 512'(o_crvalid), 512'(0));
    end

    chk("drain_cd", 512'(exp_cd.size()), 512'(0));
    chk("drain_cr", 512'(exp_cr.size()), 512'(0));
    chk("drain_trig", 512'(exp_trig.size()), 512'(0));
    chk("end_count", 512'(ends_seen), 512'(exp_ends));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
